// File: rtl/multi_cycle_shifter.sv
// Iterative SLL/SRL/SRA/ROR shifter, STEP bits per clock, start/busy/done handshake.
// Optional rotate: define MULTI_CYCLE_SHIFTER_ROR_EN (else op=11 acts as SLL).
// Ports: clk, rst_n (async low), start, op[1:0], a[WIDTH], shamt[SHAMT_W]
//        -> busy (SHIFT state), done (1-cycle pulse), result[WIDTH] (held).
module multi_cycle_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   localparam int SHAMT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [1:0] OP_SLL = 2'd0;
   localparam logic [1:0] OP_SRL = 2'd1;
   localparam logic [1:0] OP_SRA = 2'd2;
   localparam logic [1:0] OP_ROR = 2'd3;

   localparam logic [SHAMT_W-1:0] W_AMT    = SHAMT_W'(WIDTH);
   localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

   logic [1:0]         state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] rem;
   logic               sign_q;

   logic               accept;
   logic [1:0]         op_eff;
   logic [SHAMT_W-1:0] eff_shamt;
   logic [SHAMT_W-1:0] k;
   logic [SHAMT_W-1:0] inv_k;
   logic [SHAMT_W-1:0] rem_nxt;
   logic [WIDTH-1:0]   shifted;

   assign accept = start && (state != S_SHIFT);
   assign busy   = (state == S_SHIFT);
   assign done   = (state == S_DONE);

   // Linear shifts saturate at WIDTH; rotate only needs the amount mod WIDTH.
   always_comb begin
      op_eff    = op;
      eff_shamt = (shamt > W_AMT) ? W_AMT : shamt;
`ifdef MULTI_CYCLE_SHIFTER_ROR_EN
      if (op == OP_ROR) begin
         eff_shamt = {1'b0, shamt[SHAMT_W-2:0]};
      end
`else
      if (op == OP_ROR) begin
         op_eff = OP_SLL;
      end
`endif
   end

   assign k       = (rem > STEP_AMT) ? STEP_AMT : rem;
   assign inv_k   = W_AMT - k;
   assign rem_nxt = rem - k;

   // inv_k may equal WIDTH when k==0; an over-width shift yields zero.
   always_comb begin
      shifted = acc;
      case (op_q)
         OP_SLL: shifted = acc << k;
         OP_SRL: shifted = acc >> k;
         OP_SRA: shifted = (acc >> k) | ({WIDTH{sign_q}} << inv_k);
`ifdef MULTI_CYCLE_SHIFTER_ROR_EN
         OP_ROR: shifted = (acc >> k) | (acc << inv_k);
`endif
         default: shifted = acc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_q   <= 2'd0;
         acc    <= '0;
         rem    <= '0;
         sign_q <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op_q   <= op_eff;
                  acc    <= a;
                  rem    <= eff_shamt;
                  sign_q <= a[WIDTH-1];
                  if (eff_shamt == '0) begin
                     state  <= S_DONE;
                     result <= a;
                  end else begin
                     state <= S_SHIFT;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               acc <= shifted;
               rem <= rem_nxt;
               if (rem_nxt == '0) begin
                  state  <= S_DONE;
                  result <= shifted;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_shifter.sv
// Scoreboard bench for multi_cycle_shifter (WIDTH=32, STEP=4).
// Honours MULTI_CYCLE_SHIFTER_ROR_EN in its reference model.
module tb_multi_cycle_shifter;

   localparam int W    = 32;
   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = '0;
   logic [5:0]  shamt = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   multi_cycle_shifter #(.WIDTH(W), .STEP(STEP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .a(a), .shamt(shamt), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          dcyc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          last_done = 0;
   logic [31:0] held = '0;

   function automatic int eff_amt(input logic [1:0] o, input int sh);
`ifdef MULTI_CYCLE_SHIFTER_ROR_EN
      if (o == 2'd3) return sh % W;
`endif
      return (sh > W) ? W : sh;
   endfunction

   function automatic logic [31:0] ref_res(input logic [1:0] o,
                                           input logic [31:0] x,
                                           input int sh);
      int s;
`ifndef MULTI_CYCLE_SHIFTER_ROR_EN
      if (o == 2'd3) o = 2'd0;
`endif
      case (o)
         2'd0: return (sh >= W) ? 32'h0 : (x << sh);
         2'd1: return (sh >= W) ? 32'h0 : (x >> sh);
         2'd2: return $signed(x) >>> ((sh >= W) ? W - 1 : sh);
         default: begin
            s = sh % W;
            return (s == 0) ? x : ((x >> s) | (x << (W - s)));
         end
      endcase
   endfunction

   task automatic drive(input logic s, input logic [1:0] o,
                        input logic [31:0] x, input logic [5:0] sh);
      exp_t e;
      @(negedge clk);
      start = s;
      op    = o;
      a     = x;
      shamt = sh;
      @(posedge clk);
      #1;
      if (s && (cyc - 1 >= last_done)) begin
         e.res  = ref_res(o, x, int'(sh));
         e.dcyc = cyc + (eff_amt(o, int'(sh)) + STEP - 1) / STEP;
         q.push_back(e);
         last_done = e.dcyc;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (q.size() == 0 && cyc > last_done) break;
         drive(1'b0, 2'd0, 32'h0, 6'd0);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("busy_done_excl", 32'(busy && done), 32'h0);
         if (done) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: cyc %0d result %h", cyc, result);
            end else begin
               e = q.pop_front();
               chk("result", result, e.res);
               chk("done_cycle", 32'(cyc), 32'(e.dcyc));
               held = e.res;
            end
         end else begin
            chk("result_held", result, held);
            if (q.size() > 0 && cyc > q[0].dcyc) begin
               checks++;
               failures++;
               $display("FAIL missing_done: cyc %0d expected at %0d", cyc, q[0].dcyc);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [5:0] sh;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_result", result, 32'h0);
      #2 rst_n = 1'b1;

      drive(1'b1, 2'd0, 32'h0000_0001, 6'd4);  drain();
      drive(1'b1, 2'd2, 32'h8000_0000, 6'd31); drain();
      drive(1'b1, 2'd1, 32'h8000_0000, 6'd31); drain();
      drive(1'b1, 2'd0, 32'h1234_5678, 6'd0);  drain();
      drive(1'b1, 2'd2, 32'h1234_5678, 6'd0);  drain();
      drive(1'b1, 2'd3, 32'h1234_5678, 6'd0);  drain();
      drive(1'b1, 2'd0, 32'h1234_5678, 6'd32); drain();
      drive(1'b1, 2'd2, 32'h8000_0000, 6'd32); drain();
      drive(1'b1, 2'd1, 32'hFFFF_FFFF, 6'd63); drain();
      drive(1'b1, 2'd3, 32'h0000_000F, 6'd4);  drain();
      drive(1'b1, 2'd3, 32'h0000_000F, 6'd36); drain();
      drive(1'b1, 2'd3, 32'hA5A5_0001, 6'd32); drain();

      // start pulsed mid-shift, then held across DONE for a back-to-back op
      drive(1'b1, 2'd1, 32'hF000_0000, 6'd20);
      drive(1'b0, 2'd0, 32'h0, 6'd0);
      drive(1'b1, 2'd0, 32'hDEAD_BEEF, 6'd3);
      for (int i = 0; i < 4; i++) drive(1'b1, 2'd2, 32'h8765_4321, 6'd9);
      drain();

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0: sh = 6'd0;
            1: sh = 6'd32;
            2: sh = 6'($urandom_range(33, 63));
            default: sh = 6'($urandom_range(0, 31));
         endcase
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
               $urandom, sh);
      end
      drive(1'b0, 2'd0, 32'h0, 6'd0);
      drain();

      // reset in the middle of a long shift
      drive(1'b1, 2'd0, 32'h0000_0001, 6'd32);
      drive(1'b0, 2'd0, 32'h0, 6'd0);
      drive(1'b0, 2'd0, 32'h0, 6'd0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_result", result, 32'h0);
      q.delete();
      held = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      last_done = 0;
      repeat (20) drive(1'b0, 2'd0, 32'h0, 6'd0);

      drive(1'b1, 2'd2, 32'hC000_0000, 6'd5);
      drain();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d outstanding, expected 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
